// File: rtl/mod_counter.sv
`timescale 1ns/1ps
// mod_counter: synchronous modulo-N up/down counter with clear, load,
// enable, direction, wrap pulse, optional one-shot stop and cascade tc.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset
//   clear    - synchronous clear to 0 (also clears done)
//   load     - synchronous load of load_val, clamped to MODULUS-1
//   load_val - value to load
//   en       - count enable
//   up_dn    - 1 = count up, 0 = count down
//   count    - registered count
//   tc       - combinational terminal count for cascading
//   wrap     - registered one-cycle pulse after a wrap
//   done     - registered one-shot completion flag
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    generate
        if (WIDTH < 1 || MODULUS < 2 ||
            longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_param_check
            $error("mod_counter: need WIDTH>=1 and 2<=MODULUS<=2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] term;
    logic             at_term;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             done_nxt;

    assign term    = up_dn ? MAXV : '0;
    assign at_term = (count == term);
    assign tc      = en & at_term & ~done;

    // Explicit compare keeps the wrap correct for any MODULUS, including
    // the power-of-two case where natural overflow would also work.
    always_comb begin
        stepped = count;
        if (up_dn) begin
            stepped = at_term ? '0 : count + 1'b1;
        end else begin
            stepped = at_term ? MAXV : count - 1'b1;
        end
    end

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        done_nxt  = done;
        if (clear) begin
            count_nxt = '0;
            done_nxt  = 1'b0;
        end else if (load) begin
            count_nxt = (load_val > MAXV) ? MAXV : load_val;
            done_nxt  = 1'b0;
        end else if (en) begin
            if (ONE_SHOT != 0) begin
                // Stop at the terminal value; only clear/load restart.
                if (!done) begin
                    if (at_term) begin
                        done_nxt = 1'b1;
                    end else begin
                        count_nxt = stepped;
                    end
                end
            end else begin
                count_nxt = stepped;
                wrap_nxt  = at_term;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
`timescale 1ns/1ps
// tb_mod_counter: self-checking bench for mod_counter.
// Covers default, modulus-10, one-shot and cascaded configurations.
module tb_mod_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instances 0..2 driven through arrays; 3/4 form a cascade.
    logic       clr [3];
    logic       ld  [3];
    logic [3:0] lv  [3];
    logic       en  [3];
    logic       up  [3];

    logic [3:0] c0, c1, c2, c3, c4;
    logic       t0, t1, t2, t3, t4;
    logic       w0, w1, w2, w3, w4;
    logic       d0, d1, d2, d3, d4;
    logic       en3;

    mod_counter #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) u0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .load(ld[0]),
        .load_val(lv[0]), .en(en[0]), .up_dn(up[0]),
        .count(c0), .tc(t0), .wrap(w0), .done(d0));

    mod_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) u1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .load(ld[1]),
        .load_val(lv[1]), .en(en[1]), .up_dn(up[1]),
        .count(c1), .tc(t1), .wrap(w1), .done(d1));

    mod_counter #(.WIDTH(4), .MODULUS(6), .ONE_SHOT(1)) u2 (
        .clk(clk), .rst(rst), .clear(clr[2]), .load(ld[2]),
        .load_val(lv[2]), .en(en[2]), .up_dn(up[2]),
        .count(c2), .tc(t2), .wrap(w2), .done(d2));

    mod_counter #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) u_lo (
        .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .en(en3), .up_dn(1'b1),
        .count(c3), .tc(t3), .wrap(w3), .done(d3));

    mod_counter #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) u_hi (
        .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .en(t3), .up_dn(1'b1),
        .count(c4), .tc(t4), .wrap(w4), .done(d4));

    typedef struct {
        int cnt;
        bit wrap;
        bit done;
    } st_t;

    typedef struct {
        int k;
        int cnt;
        bit wrap;
        bit done;
    } exp_t;

    typedef struct {
        bit clr;
        bit ld;
        int lv;
        bit en;
        bit up;
        int cnt;
        bit wrap;
        bit done;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];
    st_t  mst [3];
    int   mods [3] = '{16, 10, 6};
    bit   oss  [3] = '{1'b0, 1'b0, 1'b1};
    vec_t tbl [12];

    task automatic chk(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic st_t model(int m, bit os, st_t s, bit c_i, bit l_i,
                                  int v_i, bit e_i, bit u_i);
        st_t r;
        int  t;
        r = s;
        r.wrap = 1'b0;
        if (c_i) begin
            r.cnt = 0;
            r.done = 1'b0;
        end else if (l_i) begin
            r.cnt = (v_i >= m) ? m - 1 : v_i;
            r.done = 1'b0;
        end else if (e_i) begin
            t = u_i ? m - 1 : 0;
            if (os) begin
                if (!s.done) begin
                    if (s.cnt == t) r.done = 1'b1;
                    else r.cnt = u_i ? s.cnt + 1 : s.cnt - 1;
                end
            end else if (u_i) begin
                r.cnt = (s.cnt + 1) % m;
                r.wrap = (s.cnt == m - 1);
            end else begin
                r.cnt = (s.cnt + m - 1) % m;
                r.wrap = (s.cnt == 0);
            end
        end
        return r;
    endfunction

    task automatic rd(int k, output int c, output bit w, output bit d,
                      output bit t);
        c = 0; w = 0; d = 0; t = 0;
        case (k)
            0: begin c = int'(c0); w = w0; d = d0; t = t0; end
            1: begin c = int'(c1); w = w1; d = d1; t = t1; end
            default: begin c = int'(c2); w = w2; d = d2; t = t2; end
        endcase
    endtask

    // Drive one cycle on instance k; expected result is queued at drive
    // time and popped after the edge.
    task automatic apply(int k, bit c_i, bit l_i, int v_i, bit e_i, bit u_i,
                         bit use_tbl = 1'b0, int e_cnt = 0,
                         bit e_wrap = 1'b0, bit e_done = 1'b0);
        int   c;
        bit   w, d, t, tc_exp;
        st_t  ns;
        exp_t e;
        clr[k] = c_i; ld[k] = l_i; lv[k] = 4'(v_i);
        en[k] = e_i; up[k] = u_i;
        #1;
        rd(k, c, w, d, t);
        tc_exp = e_i && !mst[k].done &&
                 (mst[k].cnt == (u_i ? mods[k] - 1 : 0));
        chk($sformatf("tc[%0d]", k), int'(t), int'(tc_exp));
        ns = model(mods[k], oss[k], mst[k], c_i, l_i, v_i, e_i, u_i);
        e.k = k;
        e.cnt = use_tbl ? e_cnt : ns.cnt;
        e.wrap = use_tbl ? e_wrap : ns.wrap;
        e.done = use_tbl ? e_done : ns.done;
        q.push_back(e);
        mst[k] = ns;
        @(posedge clk);
        #1;
        e = q.pop_front();
        rd(e.k, c, w, d, t);
        chk($sformatf("count[%0d]", e.k), c, e.cnt);
        chk($sformatf("wrap[%0d]", e.k), int'(w), int'(e.wrap));
        chk($sformatf("done[%0d]", e.k), int'(d), int'(e.done));
        clr[k] = 0; ld[k] = 0; lv[k] = 0; en[k] = 0; up[k] = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            clr[i] = 0; ld[i] = 0; lv[i] = 0; en[i] = 0; up[i] = 0;
            mst[i] = '{cnt: 0, wrap: 1'b0, done: 1'b0};
        end
        en3 = 0;
        tbl = '{
            '{0, 1, 13, 0, 1, 9, 0, 0},
            '{0, 1,  4, 1, 1, 4, 0, 0},
            '{0, 0,  0, 1, 1, 5, 0, 0},
            '{0, 1,  9, 0, 1, 9, 0, 0},
            '{0, 0,  0, 1, 1, 0, 1, 0},
            '{0, 0,  0, 0, 1, 0, 0, 0},
            '{0, 0,  0, 1, 0, 9, 1, 0},
            '{0, 0,  0, 1, 0, 8, 0, 0},
            '{0, 1, 15, 1, 0, 9, 0, 0},
            '{1, 1,  3, 1, 1, 0, 0, 0},
            '{0, 1, 10, 0, 0, 9, 0, 0},
            '{0, 1,  0, 0, 1, 0, 0, 0}
        };

        // Reset state; tc may be high in reset for down counting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c0", int'(c0), 0);
        chk("rst_c1", int'(c1), 0);
        chk("rst_c2", int'(c2), 0);
        chk("rst_w0", int'(w0), 0);
        chk("rst_d2", int'(d2), 0);
        en[0] = 1; up[0] = 0;
        #1;
        chk("rst_tc_down", int'(t0), 1);
        up[0] = 1;
        #1;
        chk("rst_tc_up", int'(t0), 0);
        en[0] = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Default: up 20 clocks, wrap after 15.
        for (int i = 0; i < 20; i++) apply(0, 0, 0, 0, 1, 1);
        chk("def_after20", int'(c0), 4);

        // Modulus 10 counting down from reset.
        for (int i = 0; i < 12; i++) apply(1, 0, 0, 0, 1, 0);

        // Table vectors: load clamp, priority, wrap both ways.
        foreach (tbl[i])
            apply(1, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up,
                  1'b1, tbl[i].cnt, tbl[i].wrap, tbl[i].done);

        // One-shot modulus 6.
        for (int i = 0; i < 8; i++) apply(2, 0, 0, 0, 1, 1);
        chk("os_hold", int'(c2), 5);
        chk("os_done", int'(d2), 1);
        for (int i = 0; i < 2; i++) apply(2, 0, 0, 0, 1, 0);
        chk("os_dirchg_hold", int'(c2), 5);
        apply(2, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) apply(2, 0, 0, 0, 1, 1);
        chk("os_restart", int'(c2), 3);
        chk("os_restart_done", int'(d2), 0);

        // Async reset mid-cycle with count at 7.
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 1);
        chk("pre_rst_c0", int'(c0), 7);
        #3;
        rst = 1;
        #1;
        chk("async_rst_c0", int'(c0), 0);
        chk("async_rst_w0", int'(w0), 0);
        for (int i = 0; i < 3; i++)
            mst[i] = '{cnt: 0, wrap: 1'b0, done: 1'b0};
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        apply(0, 0, 1, 9, 1, 1);
        apply(0, 1, 1, 9, 1, 1);
        chk("clr_over_load", int'(c0), 0);
        apply(0, 0, 0, 0, 1, 1);
        apply(0, 0, 0, 0, 1, 1);
        chk("resume_c0", int'(c0), 2);

        // Cascade: lower tc enables upper stage.
        en3 = 1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            chk("casc_val", int'({c4, c3}), i % 256);
            chk("casc_tc", int'(t4), int'(i % 256 == 255));
            chk("casc_wrap", int'(w3), int'(i % 16 == 0));
        end
        en3 = 0;
        chk("casc_done", int'({d4, d3, w4}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
